// File: rtl/fifo_wr_scheduler_pkg.sv
// Shared types and constants for the capture FIFO write scheduler.
package fifo_wr_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int PAYLOAD_W = 16;
    localparam int TAG_W     = 2;
    localparam int DATA_W    = TAG_W + PAYLOAD_W;
    localparam int TAG_MSB   = 17;
    localparam int TAG_LSB   = 16;

    localparam logic [TAG_W-1:0] TAG_MARKER = 2'b11;

    function automatic logic [PAYLOAD_W-1:0] sat_add(input logic [PAYLOAD_W-1:0] a,
                                                     input logic [PAYLOAD_W-1:0] b);
        logic [PAYLOAD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[PAYLOAD_W] ? {PAYLOAD_W{1'b1}} : sum[PAYLOAD_W-1:0];
    endfunction

endpackage

// File: rtl/fifo_wr_scheduler_rr_arbiter.sv
// Round-robin grant over N requesters; priority starts just after the last winner.
module fifo_wr_scheduler_rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic             fe_clk,
    input  logic             reset_i,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] last;

    function automatic int wrap(input int v);
        return v % N;
    endfunction

    // Scan farthest-to-nearest so the requester right after 'last' overrides the others.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        if (en) begin
            for (int k = N; k >= 1; k--) begin
                if (req[wrap(int'(last) + k)]) begin
                    gnt                       = '0;
                    gnt[wrap(int'(last) + k)] = 1'b1;
                    gnt_idx                   = IDX_W'(wrap(int'(last) + k));
                end
            end
        end
    end

    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            last <= IDX_W'(N - 1);
        end else if (|gnt) begin
            last <= gnt_idx;
        end
    end

endmodule

// File: rtl/fifo_wr_scheduler.sv
// Write-side scheduler for the shared 18-bit capture FIFO: slots, tagging,
// drop accounting with marker words, and the capture sequencing FSM.
module fifo_wr_scheduler
    import fifo_wr_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 20
) (
    input  logic                         fe_clk,
    input  logic                         reset_i,
    input  logic                         I_arm,
    input  logic                         I_trigger,
    input  logic                         I_stop,
    input  logic [CNT_W-1:0]             I_max_words,
    input  logic [NUM_REQ-1:0]           I_req_valid,
    input  logic [NUM_REQ*PAYLOAD_W-1:0] I_req_data,
    input  logic                         I_fifo_write_allowed,
    input  logic                         I_fifo_full,
    input  logic                         I_clear_flags,
    output logic                         O_fifo_wr,
    output logic [DATA_W-1:0]            O_fifo_data,
    output logic                         O_drop_sticky,
    output logic                         O_capture_done,
    output logic [2:0]                   O_state,
    output logic [CNT_W-1:0]             O_words_written
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t                 state, state_nxt;
    logic [NUM_REQ-1:0]     slot_full;
    logic [PAYLOAD_W-1:0]   slot_data [NUM_REQ];
    logic [PAYLOAD_W-1:0]   drop_cnt, drop_inc, drop_base;
    logic                   marker_pend;
    logic [CNT_W-1:0]       max_words, words_written;
    logic                   drop_sticky, fifo_wr;
    logic [DATA_W-1:0]      fifo_data, wr_data;

    logic                   limit_hit, grant_ok, grant_marker, any_grant;
    logic                   arm_ok, discard;
    logic [NUM_REQ-1:0]     req_gnt, accept, drop;
    logic [IDX_W-1:0]       gnt_idx;

    assign limit_hit    = (max_words != '0) && (words_written == max_words);
    assign grant_ok     = I_fifo_write_allowed && !I_fifo_full && !limit_hit &&
                          ((state == ST_CAPTURE) || (state == ST_FLUSH));
    // The marker outranks every slot so its place in the stream marks where the gap was.
    assign grant_marker = grant_ok && marker_pend;
    assign any_grant    = grant_marker || (|req_gnt);

    fifo_wr_scheduler_rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .fe_clk  (fe_clk),
        .reset_i (reset_i),
        .en      (grant_ok && !marker_pend),
        .req     (slot_full),
        .gnt     (req_gnt),
        .gnt_idx (gnt_idx)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        arm_ok    = 1'b0;
        discard   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (I_arm) begin
                    state_nxt = ST_ARMED;
                    arm_ok    = 1'b1;
                end
            end
            ST_ARMED: begin
                if (I_stop)         state_nxt = ST_IDLE;
                else if (I_trigger) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (limit_hit) begin
                    state_nxt = ST_DONE;
                    discard   = 1'b1;
                end else if (I_stop) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (limit_hit || I_stop) begin
                    state_nxt = ST_DONE;
                    discard   = 1'b1;
                end else if ((slot_full == '0) && !marker_pend) begin
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A slot being granted this cycle can take a new word at the same edge.
    always_comb begin
        accept   = '0;
        drop     = '0;
        drop_inc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state == ST_CAPTURE) && I_req_valid[i]) begin
                if (!slot_full[i] || req_gnt[i]) accept[i] = 1'b1;
                else                             drop[i]   = 1'b1;
            end
            drop_inc = drop_inc + PAYLOAD_W'(drop[i]);
        end
        drop_base = grant_marker ? '0 : drop_cnt;
    end

    always_comb begin
        wr_data = '0;
        if (grant_marker) begin
            wr_data[TAG_MSB:TAG_LSB]  = TAG_MARKER;
            wr_data[PAYLOAD_W-1:0]    = drop_cnt;
        end else begin
            wr_data[TAG_MSB:TAG_LSB]  = TAG_W'(gnt_idx);
            wr_data[PAYLOAD_W-1:0]    = slot_data[gnt_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            slot_full <= '0;
        end else begin
            state <= state_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (discard)         slot_full[i] <= 1'b0;
                else if (accept[i])  slot_full[i] <= 1'b1;
                else if (req_gnt[i]) slot_full[i] <= 1'b0;
            end
        end
    end

    // NOTE: payload storage has no reset; slot_full alone qualifies it, keeping reset off the data path.
    always_ff @(posedge fe_clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) slot_data[i] <= I_req_data[PAYLOAD_W*i +: PAYLOAD_W];
        end
    end

    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            max_words     <= '0;
            words_written <= '0;
            drop_cnt      <= '0;
            marker_pend   <= 1'b0;
            drop_sticky   <= 1'b0;
            fifo_wr       <= 1'b0;
            fifo_data     <= '0;
        end else begin
            if (arm_ok) begin
                max_words     <= I_max_words;
                words_written <= '0;
                drop_cnt      <= '0;
                marker_pend   <= 1'b0;
            end else begin
                if (any_grant) words_written <= words_written + CNT_W'(1);
                if (|drop) begin
                    drop_cnt    <= sat_add(drop_base, drop_inc);
                    marker_pend <= 1'b1;
                end else if (grant_marker) begin
                    drop_cnt    <= '0;
                    marker_pend <= 1'b0;
                end
                if (discard) marker_pend <= 1'b0;
            end

            if (|drop)              drop_sticky <= 1'b1;
            else if (I_clear_flags) drop_sticky <= 1'b0;

            fifo_wr <= any_grant;
            if (any_grant) fifo_data <= wr_data;
        end
    end

    assign O_fifo_wr       = fifo_wr;
    assign O_fifo_data     = fifo_data;
    assign O_drop_sticky   = drop_sticky;
    assign O_capture_done  = (state == ST_DONE);
    assign O_state         = state;
    assign O_words_written = words_written;

endmodule

// File: tb/tb_fifo_wr_scheduler.sv
// Scoreboard bench for fifo_wr_scheduler: a rule-level model predicts each write,
// a monitor pops and compares every word the DUT presents.
module tb_fifo_wr_scheduler;

    localparam int NUM_REQ = 3;
    localparam int CNT_W   = 20;

    localparam int S_IDLE = 0, S_ARMED = 1, S_CAPTURE = 2, S_FLUSH = 3, S_DONE = 4;

    logic                   fe_clk = 1'b0;
    logic                   reset_i;
    logic                   arm, trigger, stop, allowed, full, clear;
    logic [CNT_W-1:0]       max_words;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*16-1:0]  req_data;

    logic                   o_wr, o_sticky, o_done;
    logic [17:0]            o_data;
    logic [2:0]             o_state;
    logic [CNT_W-1:0]       o_words;

    int checks   = 0;
    int failures = 0;

    logic [17:0] exp_q   [$];
    logic [17:0] dut_log [$];
    logic [17:0] mon_exp;

    int          m_state, m_last, m_drops, m_max, m_words;
    bit          m_marker, m_sticky, m_wr;
    bit          m_full [NUM_REQ];
    logic [15:0] m_data [NUM_REQ];

    fifo_wr_scheduler #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (CNT_W)
    ) dut (
        .fe_clk               (fe_clk),
        .reset_i              (reset_i),
        .I_arm                (arm),
        .I_trigger            (trigger),
        .I_stop               (stop),
        .I_max_words          (max_words),
        .I_req_valid          (req_valid),
        .I_req_data           (req_data),
        .I_fifo_write_allowed (allowed),
        .I_fifo_full          (full),
        .I_clear_flags        (clear),
        .O_fifo_wr            (o_wr),
        .O_fifo_data          (o_data),
        .O_drop_sticky        (o_sticky),
        .O_capture_done       (o_done),
        .O_state              (o_state),
        .O_words_written      (o_words)
    );

    always #5 fe_clk = ~fe_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] log_at(input int i);
        return (i < dut_log.size()) ? dut_log[i] : 18'bx;
    endfunction

    // Scoreboard monitor: every presented write must match the oldest prediction.
    always @(posedge fe_clk) begin
        #2;
        if (o_wr === 1'b1) begin
            dut_log.push_back(o_data);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got %h expected no write (t=%0t)", o_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("wr_data", 32'(o_data), 32'(mon_exp));
            end
        end
    end

    task automatic model_reset();
        m_state = S_IDLE; m_last = NUM_REQ - 1; m_drops = 0; m_max = 0; m_words = 0;
        m_marker = 0; m_sticky = 0; m_wr = 0;
        for (int i = 0; i < NUM_REQ; i++) m_full[i] = 0;
        exp_q.delete();
    endtask

    // One cycle of the specified rules, applied to the inputs currently driven.
    task automatic model_step();
        bit lim, ok, gm, disc, empty;
        int g, nd, ns, idx;
        bit acc [NUM_REQ];
        lim   = (m_max != 0) && (m_words == m_max);
        ok    = allowed && !full && !lim && (m_state == S_CAPTURE || m_state == S_FLUSH);
        empty = !m_marker;
        for (int i = 0; i < NUM_REQ; i++) if (m_full[i]) empty = 0;
        gm = ok && m_marker;
        g  = -1;
        if (ok && !m_marker) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (m_last + k) % NUM_REQ;
                if (g < 0 && m_full[idx]) g = idx;
            end
        end
        m_wr = gm || (g >= 0);
        if (gm) begin
            exp_q.push_back({2'b11, 16'(m_drops)});
            m_words++;
        end else if (g >= 0) begin
            exp_q.push_back({2'(g), m_data[g]});
            m_last = g;
            m_words++;
        end

        nd = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            acc[i] = 0;
            if (m_state == S_CAPTURE && req_valid[i]) begin
                if (!m_full[i] || g == i) acc[i] = 1;
                else nd++;
            end
        end
        if (nd > 0) begin
            m_drops = (gm ? 0 : m_drops) + nd;
            if (m_drops > 65535) m_drops = 65535;
            m_marker = 1;
            m_sticky = 1;
        end else begin
            if (gm) begin m_drops = 0; m_marker = 0; end
            if (clear) m_sticky = 0;
        end

        ns = m_state; disc = 0;
        case (m_state)
            S_IDLE, S_DONE: if (arm) begin
                ns = S_ARMED; m_max = int'(max_words); m_words = 0; m_drops = 0; m_marker = 0;
            end
            S_ARMED:   if (stop) ns = S_IDLE; else if (trigger) ns = S_CAPTURE;
            S_CAPTURE: if (lim) begin ns = S_DONE; disc = 1; end else if (stop) ns = S_FLUSH;
            S_FLUSH:   if (lim || stop) begin ns = S_DONE; disc = 1; end else if (empty) ns = S_DONE;
            default: ns = S_IDLE;
        endcase
        if (disc) m_marker = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (disc) m_full[i] = 0;
            else if (acc[i]) begin m_full[i] = 1; m_data[i] = req_data[16*i +: 16]; end
            else if (g == i) m_full[i] = 0;
        end
        m_state = ns;
    endtask

    task automatic idle_inputs();
        arm = 0; trigger = 0; stop = 0; clear = 0; req_valid = '0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge fe_clk);
        #1;
        check("state", 32'(o_state), 32'(m_state));
        check("words_written", 32'(o_words), 32'(m_words));
        check("drop_sticky", 32'(o_sticky), 32'(m_sticky));
        check("capture_done", 32'(o_done), 32'(m_state == S_DONE));
        check("fifo_wr", 32'(o_wr), 32'(m_wr));
        idle_inputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int dens;
        idle_inputs();
        allowed = 1; full = 0; max_words = '0; req_data = '0;
        model_reset();
        reset_i = 1'b1;
        #1;
        check("rst_state", 32'(o_state), 0);
        check("rst_wr", 32'(o_wr), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_words", 32'(o_words), 0);
        check("rst_sticky", 32'(o_sticky), 0);
        check("rst_done", 32'(o_done), 0);
        @(posedge fe_clk); @(posedge fe_clk); #1;
        reset_i = 1'b0;

        // Single word latency: valid in N, write visible in N+2.
        max_words = '0; arm = 1; cycle();
        trigger = 1; cycle();
        dut_log.delete();
        req_valid = 3'b001; req_data[15:0] = 16'h1234; cycle();
        check("t1_no_wr_n1", 32'(o_wr), 0);
        cycle();
        #2;
        check("t1_wr_n2", 32'(o_wr), 1);
        check("t1_word", 32'(log_at(0)), 32'h01234);
        check("t1_words", 32'(o_words), 1);

        // All requesters every cycle, then stop and drain.
        for (int c = 0; c < 6; c++) begin
            req_valid = 3'b111;
            req_data  = {16'hC000 + 16'(c), 16'hB000 + 16'(c), 16'hA000 + 16'(c)};
            cycle();
        end
        stop = 1; cycle();
        run(10);
        check("t2_done", 32'(o_state), S_DONE);

        // Drops while blocked, then marker ahead of the held word.
        arm = 1; cycle();
        trigger = 1; cycle();
        allowed = 0;
        for (int c = 0; c < 5; c++) begin
            req_valid = 3'b010; req_data[31:16] = (c == 0) ? 16'hBEEF : 16'h5555; cycle();
        end
        check("t3_sticky", 32'(o_sticky), 1);
        dut_log.delete();
        allowed = 1; run(3);
        #2;
        check("t3_marker", 32'(log_at(0)), 32'h30004);
        check("t3_held_word", 32'(log_at(1)), 32'h1BEEF);
        check("t3_sticky_held", 32'(o_sticky), 1);
        clear = 1; cycle();
        check("t3_sticky_clr", 32'(o_sticky), 0);
        stop = 1; cycle();
        run(3);

        // Word limit.
        max_words = 4; arm = 1; cycle();
        trigger = 1; cycle();
        dut_log.delete();
        for (int c = 0; c < 8; c++) begin
            req_valid = 3'b001; req_data[15:0] = 16'h0100 + 16'(c); cycle();
        end
        check("t4_state", 32'(o_state), S_DONE);
        check("t4_done", 32'(o_done), 1);
        check("t4_words", 32'(o_words), 4);
        for (int c = 0; c < 3; c++) begin req_valid = 3'b001; cycle(); end
        #2;
        check("t4_writes", 32'(dut_log.size()), 4);

        // Stop with two slots held and writes blocked, then drain.
        max_words = 0; arm = 1; cycle();
        trigger = 1; cycle();
        allowed = 0; dut_log.delete();
        req_valid = 3'b011; req_data[31:0] = 32'h2222_1111; cycle();
        stop = 1; cycle();
        run(3);
        check("t5_flush", 32'(o_state), S_FLUSH);
        allowed = 1; run(5);
        #2;
        check("t5_writes", 32'(dut_log.size()), 2);
        check("t5_done", 32'(o_state), S_DONE);

        // Second stop in FLUSH discards the held words.
        arm = 1; cycle();
        trigger = 1; cycle();
        allowed = 0; dut_log.delete();
        req_valid = 3'b011; cycle();
        stop = 1; cycle();
        stop = 1; cycle();
        check("t5b_done", 32'(o_state), S_DONE);
        allowed = 1; run(4);
        #2;
        check("t5b_writes", 32'(dut_log.size()), 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) dens = (c % 600 == 0) ? 15 : ((c % 600 == 200) ? 45 : 85);
            case (m_state)
                S_IDLE, S_DONE: arm = ($urandom_range(0, 7) == 0);
                S_ARMED: begin
                    trigger = ($urandom_range(0, 3) == 0);
                    stop    = ($urandom_range(0, 9) == 0);
                end
                S_CAPTURE: stop = ($urandom_range(0, 59) == 0);
                default:   stop = ($urandom_range(0, 19) == 0);
            endcase
            if ($urandom_range(0, 29) == 0) arm = 1;
            if ($urandom_range(0, 29) == 0) trigger = 1;
            max_words = ($urandom_range(0, 2) == 0) ? '0 : CNT_W'($urandom_range(1, 15));
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i]        = ($urandom_range(0, 99) < dens);
                req_data[16*i +: 16] = 16'($urandom);
            end
            allowed = ($urandom_range(0, 9) != 0);
            full    = ($urandom_range(0, 19) == 0);
            clear   = ($urandom_range(0, 29) == 0);
            cycle();
        end
        allowed = 1; full = 0;
        stop = 1; cycle();
        run(8);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        // Asynchronous reset between edges in the middle of a capture.
        max_words = 0; stop = 1; cycle();
        arm = 1; cycle();
        trigger = 1; cycle();
        for (int c = 0; c < 4; c++) begin
            req_valid = 3'b111; req_data = {16'h0C0C, 16'h0B0B, 16'h0A0A}; cycle();
        end
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_wr", 32'(o_wr), 0);
        check("arst_state", 32'(o_state), 0);
        check("arst_words", 32'(o_words), 0);
        check("arst_sticky", 32'(o_sticky), 0);
        model_reset();
        @(posedge fe_clk); #1;
        reset_i = 1'b0;
        trigger = 1; cycle();
        check("arst_trigger_ignored", 32'(o_state), S_IDLE);
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
